rvb_dispatch: RTL
=================

# rvb_dispatch

Issue/writeback stage wrapped around `rvb_full`. It accepts bitmanip operations from the core pipeline together with their destination register index, and registers the operands into `rvb_full`'s `din_*` handshake. It keeps the destination indices in order in a tag FIFO, and pairs each `rvb_full` result with its index on a registered writeback port. `rvb_full` returns results in issue order, so the tag FIFO head always belongs to the next result.

## Interface
- `XLEN`, default 32: operand/result width (32 or 64).
- `MAX_INFLIGHT`, default 4: maximum number of operations accepted but not yet written back; must be a power of two, at least 2.

Ports:
- `clock` in 1: single clock. All state changes on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `in_valid` in 1; `in_ready` out 1: upstream handshake.
- `in_insn` in 32; `in_rs1`, `in_rs2`, `in_rs3` in XLEN: instruction word and operands.
- `in_rd` in 5: destination register index.
- `core_din_valid` out 1; `core_din_ready` in 1: to `rvb_full` `din_valid`/`din_ready`.
- `core_din_insn` out 32; `core_din_rs1`, `core_din_rs2`, `core_din_rs3` out XLEN: to `rvb_full`.
- `core_dout_valid` in 1; `core_dout_ready` out 1; `core_dout_rd` in XLEN: from `rvb_full`.
- `wb_valid` out 1; `wb_ready` in 1; `wb_rd_idx` out 5; `wb_data` out XLEN: writeback handshake.
- `inflight` out $clog2(MAX_INFLIGHT)+1: current tag FIFO occupancy.
- `err_underflow` out 1: sticky protocol-error flag.

## Operation
- Issue register: one entry (`iv` plus payload). `core_din_valid = iv`; `core_din_*` are driven from the payload.
- `in_ready = (!iv || core_din_ready) && (inflight != MAX_INFLIGHT)`.
- Accept (`in_valid && in_ready`):
  - the payload loads and `iv` is set;
  - `in_rd` is pushed into the tag FIFO.
- Core fire without a simultaneous accept clears `iv`.
- Writeback register: one entry. `core_dout_ready = !wb_valid || wb_ready`.
- Core result fire (`core_dout_valid && core_dout_ready`):
  - `wb_data` is loaded from `core_dout_rd` and `wb_rd_idx` from the tag FIFO head;
  - the head is popped at the same time and `wb_valid` is set.
- `wb_valid` clears on `wb_ready` when no new result is loaded.
- `inflight` counts tags from push to pop:
  - it increments on accept and decrements on result fire;
  - both in the same cycle leave it unchanged.
- Full: while `inflight == MAX_INFLIGHT`, `in_ready` stays 0 even if a pop happens in the same cycle. There is no combinational pop-to-push path.
- Empty: a core result fire while `inflight == 0` sets `err_underflow`.
  - The result is still written back, with `wb_rd_idx = 0`, and the FIFO pointers do not move.
  - `err_underflow` clears only on reset.
- FIFO pointers are `$clog2(MAX_INFLIGHT)` bits wide and wrap modulo `MAX_INFLIGHT`; full and empty are distinguished by `inflight` only.

## Timing
- Reset values:
  - `iv`, `core_din_valid`, `wb_valid` = 0;
  - `inflight` = 0, `err_underflow` = 0, FIFO pointers = 0;
  - `core_din_*`, `wb_data`, `wb_rd_idx` = 0.
- Reset asserted mid-operation discards every in-flight tag and payload. `rvb_full` must be reset in the same cycle (the system is responsible for this).
- Latency:
  - accept to `core_din_valid`: 1 cycle;
  - core result fire to `wb_valid`: 1 cycle;
  - end-to-end: 2 cycles plus `rvb_full` latency.
- Throughput: one accept and one writeback per cycle sustained when all ready signals stay high.
- Handshake rules: once `core_din_valid` or `wb_valid` is asserted, it and its payload stay stable until the handshake completes.
- Combinational ready paths: `in_ready` depends combinationally on `core_din_ready`; `core_dout_ready` depends combinationally on `wb_ready`.

## Configuration
- `RVB_DISPATCH_X0_DROP_EN` defined:
  - a result whose tag is 0 pops the FIFO on core fire but does not load the writeback register, so `wb_valid` does not assert for it;
  - `core_dout_ready` for such a result is 1 regardless of `wb_valid`.
- Not defined: `rd = 0` results are written back like any other.

## Structure
- Shared package/header `rvb_dispatch_pkg`:
  - `RVB_RD_W = 5`;
  - issue payload struct (insn, rs1..rs3);
  - writeback struct (rd_idx, data).
- One sub-module, `rvb_tag_fifo`, parameterised on width and depth. It provides push, pop, head, count and the underflow flag.

## Test plan
- Single op: accept `insn=0x60001013`, `rs1=0xF0`, `rd=7`, with all ready signals held at 1 → `wb_valid` with `wb_rd_idx=7` and `wb_data` equal to the `rvb_full` result; `inflight` returns to 0.
- Fill: with `wb_ready=0`, issue 4 ops with `rd` 1..4 → `in_ready` drops after the 4th accept. Raising `wb_ready` gives writebacks in order 1, 2, 3, 4, and `in_ready` returns the cycle after the first pop.
- Random backpressure: 10000 ops with randomised `in_valid` and `wb_ready` → `rd`/data pairing matches the golden model, and `inflight ≤ 4` throughout.
- x0: with the macro on, op `rd=0` followed by op `rd=5` → exactly one `wb_valid`, with `wb_rd_idx=5`. With the macro off → two writebacks.
- Underflow: force `core_dout_valid=1` while `inflight=0` → `err_underflow=1` and it stays set until `resetn` goes low.
- Reset: drop `resetn` with 3 ops in flight → all outputs take their reset values immediately, without waiting for a clock edge, and `inflight=0`.

Source files
------------

// File: rtl/rvb_dispatch_pkg.sv
// Shared types for the rvb_dispatch issue/writeback wrapper.
// Payload fields are sized for the widest XLEN; narrower builds zero-extend.
package rvb_dispatch_pkg;
  localparam int RVB_RD_W     = 5;
  localparam int RVB_INSN_W   = 32;
  localparam int RVB_XLEN_MAX = 64;

  typedef struct packed {
    logic [RVB_INSN_W-1:0]   insn;
    logic [RVB_XLEN_MAX-1:0] rs1;
    logic [RVB_XLEN_MAX-1:0] rs2;
    logic [RVB_XLEN_MAX-1:0] rs3;
  } rvb_issue_t;

  typedef struct packed {
    logic [RVB_RD_W-1:0]     rd_idx;
    logic [RVB_XLEN_MAX-1:0] data;
  } rvb_wb_t;
endpackage

// File: rtl/rvb_tag_fifo.sv
// In-order destination-tag FIFO. Full/empty come from count only; a pop
// while empty is ignored apart from setting the sticky underflow flag.
module rvb_tag_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop && empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/rvb_dispatch.sv
// Issue/writeback wrapper around rvb_full: registers operands, tracks rd in order.
// Optional RVB_DISPATCH_X0_DROP_EN: results destined for x0 are consumed silently.
module rvb_dispatch
  import rvb_dispatch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_insn,
  input  logic [XLEN-1:0]               in_rs1,
  input  logic [XLEN-1:0]               in_rs2,
  input  logic [XLEN-1:0]               in_rs3,
  input  logic [RVB_RD_W-1:0]           in_rd,
  output logic                          core_din_valid,
  input  logic                          core_din_ready,
  output logic [31:0]                   core_din_insn,
  output logic [XLEN-1:0]               core_din_rs1,
  output logic [XLEN-1:0]               core_din_rs2,
  output logic [XLEN-1:0]               core_din_rs3,
  input  logic                          core_dout_valid,
  output logic                          core_dout_ready,
  input  logic [XLEN-1:0]               core_dout_rd,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [RVB_RD_W-1:0]           wb_rd_idx,
  output logic [XLEN-1:0]               wb_data,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_underflow
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  rvb_issue_t          iss_q;
  rvb_wb_t             wb_q;
  logic                iv, wb_v;
  logic                accept, core_fire, res_fire, wb_load, drop;
  logic [RVB_RD_W-1:0] head;
  logic [CW-1:0]       count;

  // Full blocks accept even when a pop lands in the same cycle.
  assign in_ready  = (!iv || core_din_ready) && (count != CW'(MAX_INFLIGHT));
  assign accept    = in_valid && in_ready;
  assign core_fire = iv && core_din_ready;

`ifdef RVB_DISPATCH_X0_DROP_EN
  assign drop = (count != '0) && (head == '0);
`else
  assign drop = 1'b0;
`endif

  assign core_dout_ready = drop || !wb_v || wb_ready;
  assign res_fire        = core_dout_valid && core_dout_ready;
  assign wb_load         = res_fire && !drop;

  rvb_tag_fifo #(.W(RVB_RD_W), .DEPTH(MAX_INFLIGHT)) u_tags (
    .clock     (clock),
    .resetn    (resetn),
    .push      (accept),
    .pop       (res_fire),
    .din       (in_rd),
    .head      (head),
    .count     (count),
    .underflow (err_underflow)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iv    <= 1'b0;
      iss_q <= '0;
    end else if (accept) begin
      iv    <= 1'b1;
      iss_q <= '{insn: in_insn,
                 rs1:  RVB_XLEN_MAX'(in_rs1),
                 rs2:  RVB_XLEN_MAX'(in_rs2),
                 rs3:  RVB_XLEN_MAX'(in_rs3)};
    end else if (core_fire) begin
      iv    <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_v <= 1'b0;
      wb_q <= '0;
    end else if (wb_load) begin
      wb_v <= 1'b1;
      wb_q <= '{rd_idx: head, data: RVB_XLEN_MAX'(core_dout_rd)};
    end else if (wb_ready) begin
      wb_v <= 1'b0;
    end
  end

  assign core_din_valid = iv;
  assign core_din_insn  = iss_q.insn;
  assign core_din_rs1   = iss_q.rs1[XLEN-1:0];
  assign core_din_rs2   = iss_q.rs2[XLEN-1:0];
  assign core_din_rs3   = iss_q.rs3[XLEN-1:0];
  assign wb_valid       = wb_v;
  assign wb_rd_idx      = wb_q.rd_idx;
  assign wb_data        = wb_q.data[XLEN-1:0];
  assign inflight       = count;

  // Zero-extended upper payload bits exist only to share the package types.
  if (XLEN < RVB_XLEN_MAX) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{iss_q.rs1[RVB_XLEN_MAX-1:XLEN], iss_q.rs2[RVB_XLEN_MAX-1:XLEN],
                         iss_q.rs3[RVB_XLEN_MAX-1:XLEN], wb_q.data[RVB_XLEN_MAX-1:XLEN]};
  end
endmodule
